// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and flattened-bus field extraction for the
// display source multiplexer.
package display_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;
    localparam int         NUM_DIGITS = 4;

    // Widest source count the extraction helper accepts.
    localparam int MAX_SRC   = 16;
    localparam int SEG_BUS_W = MAX_SRC * NUM_DIGITS * 7;

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } state_t;

    function automatic logic [6:0] seg_of(input logic [SEG_BUS_W-1:0] bus,
                                          input int                   src,
                                          input int                   digit);
        return bus[(src * NUM_DIGITS + digit) * 7 +: 7];
    endfunction

endpackage

// File: rtl/digit_scanner.sv
// Prescaler plus 2-bit digit counter; the digit advances once per SCAN_DIV cycles.
module digit_scanner #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       restart,
    output logic [1:0] digit
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            digit <= '0;
        end else if (restart) begin
            presc <= '0;
            digit <= '0;
        end else if (!hold) begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                digit <= digit + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_mux_scan.sv
// Selects one of NUM_SRC frame sources for the 4-digit display and LEDs, with a
// timed blanking interval on every source change and internal digit scanning.
module display_mux_scan
    import display_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int SEL_W     = $clog2(NUM_SRC),
    parameter int LED_W     = 11,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*28-1:0]    src_seg,
    input  logic [NUM_SRC*4-1:0]     src_dp,
    input  logic [NUM_SRC*LED_W-1:0] src_led,
    input  logic [NUM_SRC-1:0]       src_led_en,
    output logic [3:0]               an,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [LED_W-1:0]         led,
    output logic [SEL_W-1:0]         active_src,
    output logic                     switching
);

    localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] pending, pending_nxt, active_nxt;
    logic [CW-1:0]    blank_cnt, cnt_nxt;
    logic             sw_nxt, restart, sel_ok;
    logic [1:0]       digit;

    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [LED_W-1:0] led_d;

    digit_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (state == BLANK),
        .restart (restart),
        .digit   (digit)
    );

    // Out-of-range selects are treated as "no request".
    assign sel_ok = (32'(sel) < NUM_SRC);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        cnt_nxt     = blank_cnt;
        active_nxt  = active_src;
        sw_nxt      = switching;
        restart     = 1'b0;
        case (state)
            RUN: begin
                if (sel_ok && sel != active_src) begin
                    state_nxt   = BLANK;
                    pending_nxt = sel;
                    cnt_nxt     = '0;
                    sw_nxt      = 1'b1;
                end
            end
            BLANK: begin
                if (sel_ok && sel != pending) begin
                    pending_nxt = sel;
                    cnt_nxt     = '0;
                end else if (blank_cnt == CW'(BLANK_CYC - 1)) begin
                    active_nxt = pending;
                    state_nxt  = RUN;
                    sw_nxt     = 1'b0;
                    restart    = 1'b1;
                end else begin
                    cnt_nxt = blank_cnt + 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        led_d = '0;
        if (state == RUN) begin
            an_d  = ~(4'b0001 << digit);
            seg_d = seg_of(SEG_BUS_W'(src_seg), int'(active_src), int'(digit));
            dp_d  = src_dp[{active_src, digit}];
            if (src_led_en[active_src])
                led_d = src_led[active_src * LED_W +: LED_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            pending    <= '0;
            blank_cnt  <= '0;
            active_src <= '0;
            switching  <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            led        <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            blank_cnt  <= cnt_nxt;
            active_src <= active_nxt;
            switching  <= sw_nxt;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            led        <= led_d;
        end
    end

endmodule

// File: tb/tb_display_mux_scan.sv
// Scoreboard bench: stimulus queues expected pin values per cycle, a negedge
// monitor pops and compares against the selected DUT instance.
module tb_display_mux_scan;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: 4 sources
    logic [1:0]  sel_a;
    logic [111:0] seg_in_a;
    logic [15:0] dp_in_a;
    logic [43:0] led_in_a;
    logic [3:0]  led_en_a;
    logic [3:0]  an_a;
    logic [6:0]  seg_a;
    logic        dp_a;
    logic [10:0] led_a;
    logic [1:0]  act_a;
    logic        sw_a;

    // DUT B: 3 sources, so sel=3 is out of range
    logic [1:0]  sel_b;
    logic [83:0] seg_in_b;
    logic [11:0] dp_in_b;
    logic [32:0] led_in_b;
    logic [2:0]  led_en_b;
    logic [3:0]  an_b;
    logic [6:0]  seg_b;
    logic        dp_b;
    logic [10:0] led_b;
    logic [1:0]  act_b;
    logic        sw_b;

    display_mux_scan #(.NUM_SRC(4), .LED_W(11), .SCAN_DIV(4), .BLANK_CYC(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .sel(sel_a), .src_seg(seg_in_a), .src_dp(dp_in_a),
        .src_led(led_in_a), .src_led_en(led_en_a), .an(an_a), .seg(seg_a), .dp(dp_a),
        .led(led_a), .active_src(act_a), .switching(sw_a));

    display_mux_scan #(.NUM_SRC(3), .LED_W(11), .SCAN_DIV(4), .BLANK_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .sel(sel_b), .src_seg(seg_in_b), .src_dp(dp_in_b),
        .src_led(led_in_b), .src_led_en(led_en_b), .an(an_b), .seg(seg_b), .dp(dp_b),
        .led(led_b), .active_src(act_b), .switching(sw_b));

    typedef struct {
        int          dut;
        logic [5:0]  care;   // an, seg, dp, led, act, sw
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [10:0] led;
        logic [1:0]  act;
        logic        sw;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    localparam logic [5:0] ALL = 6'h3F;

    logic [6:0] sa [16];
    logic [6:0] sb [12];
    logic       dp0 [4];
    logic [3:0] anv [4];

    task automatic chk(input string nm, input string f, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want)
            $display("FAIL %s.%s got=%0h want=%0h at %0t", nm, f, got, want, $time);
        else
            n_pass++;
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge.
    exp_t        me;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [10:0] o_led;
    logic [1:0]  o_act;
    logic        o_sw;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            if (me.dut == 0) begin
                o_an = an_a; o_seg = seg_a; o_dp = dp_a; o_led = led_a; o_act = act_a; o_sw = sw_a;
            end else begin
                o_an = an_b; o_seg = seg_b; o_dp = dp_b; o_led = led_b; o_act = act_b; o_sw = sw_b;
            end
            if (me.care[0]) chk(me.nm, "an",  32'(o_an),  32'(me.an));
            if (me.care[1]) chk(me.nm, "seg", 32'(o_seg), 32'(me.seg));
            if (me.care[2]) chk(me.nm, "dp",  32'(o_dp),  32'(me.dp));
            if (me.care[3]) chk(me.nm, "led", 32'(o_led), 32'(me.led));
            if (me.care[4]) chk(me.nm, "act", 32'(o_act), 32'(me.act));
            if (me.care[5]) chk(me.nm, "sw",  32'(o_sw),  32'(me.sw));
        end
    end

    task automatic step(input int dut, input string nm, input logic [5:0] care,
                        input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e,
                        input logic [10:0] led_e, input logic [1:0] act_e, input logic sw_e);
        exp_t e;
        e.dut = dut; e.care = care; e.an = an_e; e.seg = seg_e; e.dp = dp_e;
        e.led = led_e; e.act = act_e; e.sw = sw_e; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step_blank(input int dut, input string nm, input logic [1:0] act_e, input logic sw_e);
        step(dut, nm, ALL, 4'hF, 7'h7F, 1'b1, 11'h000, act_e, sw_e);
    endtask

    initial begin
        sa  = '{7'h40, 7'h79, 7'h24, 7'h30,  7'h12, 7'h02, 7'h78, 7'h00,
                7'h10, 7'h08, 7'h03, 7'h46,  7'h21, 7'h06, 7'h0E, 7'h7E};
        sb  = '{7'h01, 7'h02, 7'h04, 7'h08,  7'h10, 7'h20, 7'h40, 7'h03,
                7'h5A, 7'h33, 7'h66, 7'h0C};
        dp0 = '{1'b1, 1'b1, 1'b0, 1'b1};
        anv = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int i = 0; i < 16; i++) seg_in_a[i*7 +: 7] = sa[i];
        for (int i = 0; i < 12; i++) seg_in_b[i*7 +: 7] = sb[i];
        dp_in_a  = {4'hF, 4'hF, 4'hE, 4'hB};   // src0 digit2 and src1 digit0 lit
        led_in_a = {11'h7FF, 11'h123, 11'h2AA, 11'h055};
        led_en_a = 4'b1011;
        dp_in_b  = 12'hFFF;
        led_in_b = {11'h0F0, 11'h022, 11'h011};
        led_en_b = 3'b111;
        sel_b    = 2'd0;

        // Reset held with a pending request on sel
        rst_n = 1'b0;
        sel_a = 2'd2;
        for (int i = 0; i < 3; i++) step_blank(0, "rst", 2'd0, 1'b0);
        rst_n = 1'b1;
        sel_a = 2'd0;

        // Scan of source 0, including the wrap back to digit 0
        for (int k = 0; k < 17; k++)
            step(0, "scan", ALL, anv[(k/4)%4], sa[(k/4)%4], dp0[(k/4)%4], 11'h055, 2'd0, 1'b0);

        // Switch 0 -> 1
        sel_a = 2'd1;
        step(0, "sw_edge", ALL, 4'hE, 7'h40, 1'b1, 11'h055, 2'd0, 1'b1);
        step_blank(0, "sw_blank", 2'd0, 1'b1);
        step_blank(0, "sw_blank", 2'd0, 1'b1);
        step_blank(0, "sw_exit", 2'd1, 1'b0);
        for (int k = 0; k < 4; k++)
            step(0, "sw_new", ALL, 4'hE, 7'h12, 1'b0, 11'h2AA, 2'd1, 1'b0);
        step(0, "sw_d1", ALL, 4'hD, 7'h02, 1'b1, 11'h2AA, 2'd1, 1'b0);

        // Retarget mid-blank: 2 then 3; source 2 must never appear
        sel_a = 2'd2;
        step(0, "rt_edge", ALL, 4'hD, 7'h02, 1'b1, 11'h2AA, 2'd1, 1'b1);
        step_blank(0, "rt_blank", 2'd1, 1'b1);
        sel_a = 2'd3;
        for (int k = 0; k < 3; k++) step_blank(0, "rt_restart", 2'd1, 1'b1);
        step_blank(0, "rt_exit", 2'd3, 1'b0);
        step(0, "rt_new", ALL, 4'hE, 7'h21, 1'b1, 11'h7FF, 2'd3, 1'b0);

        // Reset asserted during BLANK
        sel_a = 2'd0;
        step(0, "rb_edge", ALL, 4'hE, 7'h21, 1'b1, 11'h7FF, 2'd3, 1'b1);
        step_blank(0, "rb_blank", 2'd3, 1'b1);
        rst_n = 1'b0;
        step_blank(0, "rb_rst", 2'd0, 1'b0);
        rst_n = 1'b1;
        step(0, "rb_run", ALL, 4'hE, 7'h40, 1'b1, 11'h055, 2'd0, 1'b0);

        // DUT B: out-of-range select ignored, then LED gating
        sel_b = 2'd3;
        for (int k = 0; k < 3; k++)
            step(1, "inv", ALL, 4'hE, 7'h01, 1'b1, 11'h011, 2'd0, 1'b0);
        sel_b    = 2'd2;
        led_en_b = 3'b011;
        led_in_b[22 +: 11] = 11'h7FF;
        step(1, "b_edge", ALL, 4'hD, 7'h02, 1'b1, 11'h011, 2'd0, 1'b1);
        step_blank(1, "b_blank", 2'd0, 1'b1);
        step_blank(1, "b_blank", 2'd0, 1'b1);
        step_blank(1, "b_exit", 2'd2, 1'b0);
        step(1, "b_gate", ALL, 4'hE, 7'h5A, 1'b1, 11'h000, 2'd2, 1'b0);
        led_en_b = 3'b111;
        step(1, "b_ungate", ALL, 4'hE, 7'h5A, 1'b1, 11'h7FF, 2'd2, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("drain", "qsize", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
